// File: rtl/skinny_sbox_step2_pipe.sv
// ---------------------------------------------------------------------------
// skinny_sbox_step2_pipe
//   First-order masked (two-share) SKINNY S-box step-2 layer for N_SBOX
//   parallel nibbles. Evaluates the quadratic map with DOM-indep AND gadgets
//   (one register stage), then a purely combinational affine layer,
//   optionally followed by an output register stage (PIPELINE=1). The
//   valid/ready pipeline uses per-stage enables that double as clock-gating
//   conditions.
//
// Parameters
//   N_SBOX    number of parallel 4-bit lanes (1..16)
//   PIPELINE  0: gadget stage only, 1: extra output register stage
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready combinational)
//   in0, in1             input shares, lane i at [4i+3:4i]
//   r                    fresh randomness, lane i: r[2i] -> P0, r[2i+1] -> P1
//   out_valid / out_ready output handshake
//   out0, out1           output shares, out0 ^ out1 = S(x)
// ---------------------------------------------------------------------------
module skinny_sbox_step2_pipe #(
   parameter int unsigned N_SBOX   = 1,
   parameter int unsigned PIPELINE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*N_SBOX-1:0]   in0,
   input  logic [4*N_SBOX-1:0]   in1,
   input  logic [2*N_SBOX-1:0]   r,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*N_SBOX-1:0]   out0,
   output logic [4*N_SBOX-1:0]   out1
);

   // Affine constant seen on share 0 when every stage-1 register is zero.
   localparam logic [4*N_SBOX-1:0] AFF_C = {N_SBOX{4'hC}};

   logic en1;

   // Stage-1 state: linear terms and DOM product terms, per share.
   // pX_in*: inner-domain product, pX_cr*: cross-domain product ^ r.
   logic                v1_q;
   logic [4*N_SBOX-1:0] lin0_q, lin1_q;
   logic [N_SBOX-1:0]   p0_in0_q, p0_cr0_q, p0_in1_q, p0_cr1_q;
   logic [N_SBOX-1:0]   p1_in0_q, p1_cr0_q, p1_in1_q, p1_cr1_q;
   logic [N_SBOX-1:0]   p0_in0_d, p0_cr0_d, p0_in1_d, p0_cr1_d;
   logic [N_SBOX-1:0]   p1_in0_d, p1_cr0_d, p1_in1_d, p1_cr1_d;

   // Affine-layer results per share.
   logic [4*N_SBOX-1:0] aff0, aff1;

   for (genvar g = 0; g < N_SBOX; g++) begin : g_lane
      logic [3:0] x0, x1;
      logic [3:0] l0, l1;
      logic [3:0] gg0, gg1;

      assign x0 = in0[4*g +: 4];
      assign x1 = in1[4*g +: 4];

      // P0 = x2 & x3
      assign p0_in0_d[g] = x0[2] & x0[3];
      assign p0_cr0_d[g] = (x0[2] & x1[3]) ^ r[2*g];
      assign p0_in1_d[g] = x1[2] & x1[3];
      assign p0_cr1_d[g] = (x1[2] & x0[3]) ^ r[2*g];
      // P1 = x0 & x3
      assign p1_in0_d[g] = x0[0] & x0[3];
      assign p1_cr0_d[g] = (x0[0] & x1[3]) ^ r[2*g+1];
      assign p1_in1_d[g] = x1[0] & x1[3];
      assign p1_cr1_d[g] = (x1[0] & x0[3]) ^ r[2*g+1];

      // Products are recombined only within their own share, after the register.
      assign l0  = lin0_q[4*g +: 4];
      assign l1  = lin1_q[4*g +: 4];
      assign gg0 = {l0[3], l0[2], l0[1] ^ p1_in0_q[g] ^ p1_cr0_q[g],
                    l0[0] ^ p0_in0_q[g] ^ p0_cr0_q[g]};
      assign gg1 = {l1[3], l1[2], l1[1] ^ p1_in1_q[g] ^ p1_cr1_q[g],
                    l1[0] ^ p0_in1_q[g] ^ p0_cr1_q[g]};

      // Constants only on share 0.
      assign aff0[4*g +: 4] = {1'b1 ^ gg0[1] ^ gg0[0],
                               1'b1 ^ gg0[3] ^ gg0[2] ^ gg0[0],
                               gg0[2] ^ gg0[0],
                               gg0[1]};
      assign aff1[4*g +: 4] = {gg1[1] ^ gg1[0],
                               gg1[3] ^ gg1[2] ^ gg1[0],
                               gg1[2] ^ gg1[0],
                               gg1[1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         lin0_q   <= '0;
         lin1_q   <= '0;
         p0_in0_q <= '0;
         p0_cr0_q <= '0;
         p0_in1_q <= '0;
         p0_cr1_q <= '0;
         p1_in0_q <= '0;
         p1_cr0_q <= '0;
         p1_in1_q <= '0;
         p1_cr1_q <= '0;
      end else begin
         if (en1) v1_q <= in_valid;
         if (en1 && in_valid) begin
            lin0_q   <= in0;
            lin1_q   <= in1;
            p0_in0_q <= p0_in0_d;
            p0_cr0_q <= p0_cr0_d;
            p0_in1_q <= p0_in1_d;
            p0_cr1_q <= p0_cr1_d;
            p1_in0_q <= p1_in0_d;
            p1_cr0_q <= p1_cr0_d;
            p1_in1_q <= p1_in1_d;
            p1_cr1_q <= p1_cr1_d;
         end
      end
   end

   assign in_ready = en1;

   if (PIPELINE != 0) begin : g_pipe
      logic                v2_q;
      logic                en2;
      logic [4*N_SBOX-1:0] out0_q, out1_q;

      assign en2 = ~v2_q | out_ready;
      assign en1 = ~v1_q | en2;

      // Share 0 is stored with the affine constant stripped so that a zeroed
      // register still presents the constant after reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            v2_q   <= 1'b0;
            out0_q <= '0;
            out1_q <= '0;
         end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
               out0_q <= aff0 ^ AFF_C;
               out1_q <= aff1;
            end
         end
      end

      assign out_valid = v2_q;
      assign out0      = out0_q ^ AFF_C;
      assign out1      = out1_q;
   end else begin : g_nopipe
      assign en1       = ~v1_q | out_ready;
      assign out_valid = v1_q;
      assign out0      = aff0;
      assign out1      = aff1;
   end

endmodule

// File: tb/tb_skinny_sbox_step2_pipe.sv
// ---------------------------------------------------------------------------
// tb_skinny_sbox_step2_pipe
//   Two DUTs (N_SBOX=4, PIPELINE=0 and PIPELINE=1) share one stimulus stream.
//   Each accepted item pushes its expected unmasked result onto a per-DUT
//   queue; a monitor pops and compares on each output handshake.
// ---------------------------------------------------------------------------
module tb_skinny_sbox_step2_pipe;

   localparam int unsigned NS = 4;
   localparam int unsigned W  = 4*NS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [W-1:0]  in0, in1;
   logic [2*NS-1:0] r;

   logic          in_ready_w  [2];
   logic          out_valid_w [2];
   logic [W-1:0]  out0_w      [2];
   logic [W-1:0]  out1_w      [2];

   skinny_sbox_step2_pipe #(.N_SBOX(NS), .PIPELINE(0)) u_p0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in0(in0), .in1(in1), .r(r), .out_valid(out_valid_w[0]),
      .out_ready(out_ready), .out0(out0_w[0]), .out1(out1_w[0]));

   skinny_sbox_step2_pipe #(.N_SBOX(NS), .PIPELINE(1)) u_p1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in0(in0), .in1(in1), .r(r), .out_valid(out_valid_w[1]),
      .out_ready(out_ready), .out0(out0_w[1]), .out1(out1_w[1]));

   typedef struct {
      logic [W-1:0] y;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t         sbq [2][$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   bit           lat_mode = 1'b0;
   int           pops [2] = '{0, 0};
   bit           stall [2] = '{1'b0, 1'b0};
   logic [W-1:0] hold0 [2];
   logic [W-1:0] hold1 [2];
   logic [W-1:0] last_out0 [2];
   logic [W-1:0] last_y [2];

   // Reference S-box, straight from the unmasked definition.
   function automatic logic [3:0] sbox_nib(input logic [3:0] x);
      bit g0, g1, g2, g3;
      g0 = x[0] ^ (x[2] & x[3]);
      g1 = x[1] ^ (x[0] & x[3]);
      g2 = x[2];
      g3 = x[3];
      return {1'b1 ^ g1 ^ g0, 1'b1 ^ g3 ^ g2 ^ g0, g2 ^ g0, g1};
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] x);
      logic [W-1:0] y;
      y = '0;
      for (int i = 0; i < NS; i++) y[4*i +: 4] = sbox_nib(x[4*i +: 4]);
      return y;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor + scoreboard push (sampled on the inactive edge).
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            sbq[d].delete();
            stall[d] = 1'b0;
         end else if (out_valid_w[d]) begin
            if (sbq[d].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out_p%0d: got out0^out1=%h, expected no output (t=%0t)",
                        d, out0_w[d] ^ out1_w[d], $time);
            end else begin
               e = sbq[d][0];
               if (stall[d]) begin
                  chk($sformatf("hold_out0_p%0d", d), 32'(out0_w[d]), 32'(hold0[d]));
                  chk($sformatf("hold_out1_p%0d", d), 32'(out1_w[d]), 32'(hold1[d]));
               end else if (e.lat) begin
                  chk($sformatf("latency_p%0d", d), 32'(cyc - e.acc), 32'(d + 1));
               end
               chk($sformatf("data_p%0d", d), 32'(out0_w[d] ^ out1_w[d]), 32'(e.y));
               last_out0[d] = out0_w[d];
               last_y[d]    = out0_w[d] ^ out1_w[d];
               if (out_ready) begin
                  void'(sbq[d].pop_front());
                  pops[d]++;
                  stall[d] = 1'b0;
               end else begin
                  stall[d] = 1'b1;
                  hold0[d] = out0_w[d];
                  hold1[d] = out1_w[d];
               end
            end
         end else begin
            if (stall[d]) chk($sformatf("valid_held_p%0d", d), 32'(out_valid_w[d]), 32'd1);
            stall[d] = 1'b0;
         end

         if (!rst && in_valid && in_ready_w[d]) begin
            e.y   = model(in0 ^ in1);
            e.acc = cyc;
            e.lat = lat_mode || (d == 0);
            sbq[d].push_back(e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_x(input logic [W-1:0] x);
      logic [31:0] t;
      t   = $urandom;
      in1 = t[W-1:0];
      in0 = x ^ in1;
      t   = $urandom;
      r   = t[2*NS-1:0];
   endtask

   task automatic rand_all();
      logic [31:0] t;
      t = $urandom;
      rand_x(t[W-1:0]);
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_out_valid_p%0d", tag, d), 32'(out_valid_w[d]), 32'd0);
         chk($sformatf("%s_out1_p%0d", tag, d), 32'(out1_w[d]), 32'd0);
         chk($sformatf("%s_out0_p%0d", tag, d), 32'(out0_w[d]), 32'h0000CCCC);
         chk($sformatf("%s_in_ready_p%0d", tag, d), 32'(in_ready_w[d]), 32'd1);
      end
   endtask

   // Single item through both DUTs; waits (bounded) for both to deliver.
   task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [2*NS-1:0] rr, input string name);
      int p0, p1;
      p0 = pops[0];
      p1 = pops[1];
      in0 = a0;
      in1 = a1;
      r   = rr;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 10 && (pops[1] == p1 || pops[0] == p0); k++) step();
      chk({name, "_delivered_p0"}, 32'(pops[0] - p0), 32'd1);
      chk({name, "_delivered_p1"}, 32'(pops[1] - p1), 32'd1);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 40 && (sbq[0].size() != 0 || sbq[1].size() != 0); k++) step();
      chk({name, "_drain_p0"}, 32'(sbq[0].size()), 32'd0);
      chk({name, "_drain_p1"}, 32'(sbq[1].size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, p1;
      logic [3:0] v;
      logic [31:0] t;

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in0 = '0;
      in1 = '0;
      r = '0;

      // Reset held with in_valid high: nothing may be accepted.
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         rand_all();
         step();
      end
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_reset_state("reset");
      step();
      @(negedge clk);
      chk("post_reset_idle_p0", 32'(out_valid_w[0]), 32'd0);
      chk("post_reset_idle_p1", 32'(out_valid_w[1]), 32'd0);
      step();

      // Directed examples and randomness independence.
      lat_mode = 1'b1;
      rand_x(16'hFC0F);
      send(in0, in1, r, "ex_fc0f");
      chk("ex_fc0f_y_p1", 32'(last_y[1]), 32'h0000E0CE);
      chk("ex_fc0f_y_p0", 32'(last_y[0]), 32'h0000E0CE);
      rand_x(16'hFFFF);
      send(in0, in1, r, "ex_ffff");
      chk("ex_ffff_y_p1", 32'(last_y[1]), 32'h0000EEEE);

      send(16'h0000, 16'h0000, 8'h00, "split_a");
      chk("split_a_out0_p0", 32'(last_out0[0]), 32'h0000CCCC);
      chk("split_a_out0_p1", 32'(last_out0[1]), 32'h0000CCCC);
      send(16'hFFFF, 16'hFFFF, 8'h00, "split_b");
      chk("split_b_out0_p0", 32'(last_out0[0]), 32'h00009999);
      chk("split_b_out0_p1", 32'(last_out0[1]), 32'h00009999);
      chk("split_b_y_p1", 32'(last_y[1]), 32'h0000CCCC);
      send(16'h0000, 16'h0000, 8'hFF, "split_c");
      chk("split_c_out0_p1", 32'(last_out0[1]), 32'h0000BBBB);
      chk("split_c_y_p1", 32'(last_y[1]), 32'h0000CCCC);

      // Full-rate stream covering every nibble value in every lane.
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         rand_x({v, ~v, v ^ 4'h5, v + 4'h3});
         in_valid = 1'b1;
         @(negedge clk);
         chk("stream_in_ready_p0", 32'(in_ready_w[0]), 32'd1);
         chk("stream_in_ready_p1", 32'(in_ready_w[1]), 32'd1);
         step();
      end
      in_valid = 1'b0;
      drain("stream");

      // Backpressure: fill from empty with out_ready low, then stall.
      lat_mode = 1'b0;
      p0 = pops[0];
      p1 = pops[1];
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rand_all();
         @(negedge clk);
         chk($sformatf("fill%0d_in_ready_p0", k), 32'(in_ready_w[0]), 32'(k == 0));
         chk($sformatf("fill%0d_in_ready_p1", k), 32'(in_ready_w[1]), 32'(k < 2));
         step();
      end
      for (int k = 0; k < 5; k++) begin
         rand_all();
         @(negedge clk);
         chk("stall_in_ready_p0", 32'(in_ready_w[0]), 32'd0);
         chk("stall_in_ready_p1", 32'(in_ready_w[1]), 32'd0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain("bp");
      chk("bp_count_p0", 32'(pops[0] - p0), 32'd1);
      chk("bp_count_p1", 32'(pops[1] - p1), 32'd2);

      // Randomised traffic with random backpressure.
      for (int k = 0; k < 400; k++) begin
         rand_all();
         t = $urandom;
         in_valid  = (t[3:0] < 4'd11);
         out_ready = (t[7:4] < 4'd11);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain("random");

      // Reset with two items in flight in the pipelined DUT.
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rand_all();
         step();
      end
      rst = 1'b1;
      rand_all();
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_reset_state("midrst");
      step();
      lat_mode = 1'b1;
      rand_all();
      send(in0, in1, r, "after_rst");
      drain("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/skinny_sbox_step2_pipe.md
# skinny_sbox_step2_pipe

Parametrised, first-order masked (two-share) SKINNY S-box step-2 layer for `N_SBOX` parallel nibbles. It evaluates a fixed quadratic map with domain-oriented AND gadgets, followed by an affine output layer, behind a valid/ready pipeline with per-stage register enables for clock gating. It sits between step 1 and step 3 of the masked SKINNY round datapath, replacing the single-nibble, handshake-less step-2 instance.

## Interface
- `N_SBOX`, default 1: number of parallel 4-bit S-box lanes (1..16).
- `PIPELINE`, default 0: 0 means one register stage (gadget); 1 adds an output register stage after the affine layer.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input shares and randomness are valid.
- `in_ready` output 1: stage 1 can accept this cycle.
- `in0`, `in1` input 4*N_SBOX: shares of x; lane i occupies bits [4i+3:4i].
- `r` input 2*N_SBOX: fresh randomness; lane i uses r[2i] for product P0 and r[2i+1] for product P1.
- `out_valid` output 1: output shares valid.
- `out_ready` input 1: downstream accepts.
- `out0`, `out1` output 4*N_SBOX: shares of y; out0 XOR out1 = y.

## Operation
- Unmasked function per lane, with x = in0 XOR in1:
  - g0 = x0 ^ (x2 & x3); g1 = x1 ^ (x0 & x3); g2 = x2; g3 = x3.
  - y3 = 1 ^ g1 ^ g0; y2 = 1 ^ g3 ^ g2 ^ g0; y1 = g2 ^ g0; y0 = g1.
- Products use DOM-indep:
  - Share 0 of a&b = a0b0 ^ REG(a0b1 ^ r).
  - Share 1 of a&b = a1b1 ^ REG(a1b0 ^ r).
  - The inner terms a0b0 and a1b1 are also registered, so both shares are aligned.
  - P0 = x2&x3 uses r[2i]; P1 = x0&x3 uses r[2i+1].
- Linear terms (x0, x1, x2, x3 per share) are registered in stage 1 alongside the products.
- Shares never combine unregistered across domains.
- Constants 1 are XORed into share 0 only; share 1 carries no constants.
- Affine layer is purely combinational on stage-1 registers.
- PIPELINE=1: out0/out1 come from stage-2 registers that capture the affine result.
- Enables:
  - last stage: en_L = ~v_L | out_ready.
  - stage k: en_k = ~v_k | en_(k+1).
  - in_ready = en_1.
- Data and valid registers load only when their enable is high; otherwise they hold, which is the clock-gating condition.
- Stage 1 captures in0, in1 and r on a transfer (in_valid & in_ready); v_1 <= in_valid whenever en_1 is high.
- Reset:
  - All valid bits go to 0 and all data registers go to 0.
  - Hence out_valid=0, out1=0, and out0 = N_SBOX copies of 4'hC (the affine constant on a zero state).
  - in_ready=1 in the cycle after reset.
- Reset mid-operation drops all in-flight items; no output handshake occurs for them.

## Timing
- Latency from accept to out_valid is 1 cycle (PIPELINE=0) or 2 cycles (PIPELINE=1).
- Throughput is one item per cycle while out_ready=1.
- in_ready is combinational from out_ready and the valid bits.
- out0, out1 and out_valid are stable while out_valid & ~out_ready.
- Bubbles collapse: with PIPELINE=1, an empty stage 2 lets stage 1 advance even when out_ready=0.
- Simultaneous accept and emit on a full pipe with out_ready=1: both happen, nothing is lost or duplicated.
- r is sampled only on accept; its value in other cycles is ignored.

## Test plan
- Reset then idle:
  - out_valid=0, out1=0, out0=4'hC per lane, in_ready=1.
  - With rst held high, in_valid=1 is never accepted.
- Exhaustive single lane (N_SBOX=1), all 16 x values with random share splits and random r:
  - out0^out1 matches the model, e.g. x=0x0 gives 0xC, x=0xF gives 0xE, x=0xC gives 0x0.
  - Check for both PIPELINE values.
- N_SBOX=4, PIPELINE=1, continuous stream with out_ready=1:
  - One result per cycle, each 2 cycles after its accept, lanes independent.
  - Example: x=0xFC0F gives y=0xE0CE.
- Backpressure:
  - out_ready=0 for 5 cycles with a full pipe: in_ready=0 and outputs hold bit-exact.
  - Releasing out_ready gives in-order delivery with no loss or duplicates.
  - PIPELINE=1 with stage 2 empty: stage 1 still fills.
- Randomness independence:
  - Same x, different r and share splits give different out0 but identical out0^out1.
  - Changing r off-accept does not affect the output.
- Reset mid-stream with 2 items in flight:
  - The next cycle shows out_valid=0 and reset output values.
  - The first item accepted after reset emerges with the correct latency.
